// File: rtl/ram_ring_buf.sv
// ram_ring_buf
//   Buffer RAM with per-byte write enables, a one-cycle-latency registered read
//   and two addressing modes. In addressed mode A selects the word. In circular
//   mode free-running write and read pointers select it.
//   A wrap counter of accepted writes pulses FULL for one cycle every DEPTH writes.
//   Memory is held in resettable flops, so an asynchronous reset clears every
//   word. A write that is pending when reset hits can never land.
// Ports
//   CLK       clock, rising edge
//   RST_N     asynchronous reset, active low (clears memory and all state)
//   CLR       synchronous clear of pointers, write counter, FULL and DO_VALID
//   MODE      0 = addressed (A), 1 = circular (WPTR/RPTR)
//   WRITE     write request
//   READ      read request
//   A         address for MODE=0 accesses
//   Di        write data
//   BE        byte enables, bit k covers Di[8k+7:8k]
//   Do        registered read data
//   DO_VALID  one-cycle strobe: Do was loaded by a read
//   FULL      one-cycle pulse after every DEPTH-th accepted write
//   WPTR      circular write pointer
//   RPTR      circular read pointer
module ram_ring_buf #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                    CLK,
   input  logic                    RST_N,
   input  logic                    CLR,
   input  logic                    MODE,
   input  logic                    WRITE,
   input  logic                    READ,
   input  logic [ADDR_WIDTH-1:0]   A,
   input  logic [DATA_WIDTH-1:0]   Di,
   input  logic [DATA_WIDTH/8-1:0] BE,
   output logic [DATA_WIDTH-1:0]   Do,
   output logic                    DO_VALID,
   output logic                    FULL,
   output logic [ADDR_WIDTH-1:0]   WPTR,
   output logic [ADDR_WIDTH-1:0]   RPTR
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int NBYTES = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DEPTH];
   logic [DATA_WIDTH-1:0] do_q, do_d;
   logic                  do_valid_q, do_valid_d;
   logic                  full_q, full_d;
   logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
   logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
   logic [ADDR_WIDTH-1:0] wcnt_q, wcnt_d;
   logic [ADDR_WIDTH-1:0] waddr_s, raddr_s;

   // Replace only the enabled bytes of a stored word.
   function automatic logic [DATA_WIDTH-1:0] merge_bytes(
      input logic [DATA_WIDTH-1:0] old_word,
      input logic [DATA_WIDTH-1:0] new_word,
      input logic [NBYTES-1:0]     be
   );
      logic [DATA_WIDTH-1:0] res;
      res = old_word;
      for (int k = 0; k < NBYTES; k++) begin
         if (be[k]) begin
            res[8*k +: 8] = new_word[8*k +: 8];
         end else begin
            res[8*k +: 8] = old_word[8*k +: 8];
         end
      end
      return res;
   endfunction

   // Address selection for both ports, driven by the current mode.
   always_comb begin
      waddr_s = A;
      raddr_s = A;
      if (MODE) begin
         waddr_s = wptr_q;
         raddr_s = rptr_q;
      end else begin
         waddr_s = A;
         raddr_s = A;
      end
   end

   // Next-state logic. The read samples mem_q, so a same-word write returns old data.
   always_comb begin
      mem_d      = mem_q;
      do_d       = do_q;
      do_valid_d = 1'b0;
      full_d     = 1'b0;
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      wcnt_d     = wcnt_q;
      if (CLR) begin
         // Clear wins over any access in the same cycle. Memory and Do are kept.
         wptr_d = {ADDR_WIDTH{1'b0}};
         rptr_d = {ADDR_WIDTH{1'b0}};
         wcnt_d = {ADDR_WIDTH{1'b0}};
      end else begin
         if (READ) begin
            do_d       = mem_q[raddr_s];
            do_valid_d = 1'b1;
            if (MODE) begin
               rptr_d = rptr_q + ADDR_WIDTH'(1);
            end else begin
               rptr_d = rptr_q;
            end
         end else begin
            do_d = do_q;
         end
         if (WRITE) begin
            // A write with no byte enabled still counts as accepted.
            mem_d[waddr_s] = merge_bytes(mem_q[waddr_s], Di, BE);
            wcnt_d         = wcnt_q + ADDR_WIDTH'(1);
            full_d         = &wcnt_q;
            if (MODE) begin
               wptr_d = wptr_q + ADDR_WIDTH'(1);
            end else begin
               wptr_d = wptr_q;
            end
         end else begin
            wcnt_d = wcnt_q;
         end
      end
   end

   // State registers, memory included, all cleared by the asynchronous reset.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         mem_q      <= '{default: {DATA_WIDTH{1'b0}}};
         do_q       <= {DATA_WIDTH{1'b0}};
         do_valid_q <= 1'b0;
         full_q     <= 1'b0;
         wptr_q     <= {ADDR_WIDTH{1'b0}};
         rptr_q     <= {ADDR_WIDTH{1'b0}};
         wcnt_q     <= {ADDR_WIDTH{1'b0}};
      end else begin
         mem_q      <= mem_d;
         do_q       <= do_d;
         do_valid_q <= do_valid_d;
         full_q     <= full_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         wcnt_q     <= wcnt_d;
      end
   end

   assign Do       = do_q;
   assign DO_VALID = do_valid_q;
   assign FULL     = full_q;
   assign WPTR     = wptr_q;
   assign RPTR     = rptr_q;

endmodule

// File: tb/tb_ram_ring_buf.sv
// Self-checking bench for ram_ring_buf (DATA_WIDTH=16, ADDR_WIDTH=3).
// A behavioural model runs alongside the DUT and is compared on every falling
// edge. Directed sequences also check hand-computed literal values.
module tb_ram_ring_buf;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clr = 1'b0, mode = 1'b0, wr = 1'b0, rd = 1'b0;
   logic [2:0]  addr = 3'd0;
   logic [15:0] di = 16'h0000;
   logic [1:0]  be = 2'b00;
   logic [15:0] dout;
   logic        do_valid, full;
   logic [2:0]  wptr, rptr;

   int n_checks = 0;
   int n_fail = 0;
   int full_seen = 0;
   bit chk_en = 1'b0;

   // Model state
   logic [15:0] m_mem [8];
   int          m_wp, m_rp, m_wtotal;
   logic [15:0] e_do;
   logic        e_valid, e_full;

   ram_ring_buf #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) dut (
      .CLK(clk), .RST_N(rst_n), .CLR(clr), .MODE(mode), .WRITE(wr), .READ(rd),
      .A(addr), .Di(di), .BE(be), .Do(dout), .DO_VALID(do_valid), .FULL(full),
      .WPTR(wptr), .RPTR(rptr)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: plain arithmetic on a word array and counters.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) m_mem[i] = 16'h0000;
         m_wp = 0; m_rp = 0; m_wtotal = 0;
         e_do = 16'h0000; e_valid = 1'b0; e_full = 1'b0;
      end else begin
         e_valid = 1'b0;
         e_full  = 1'b0;
         if (clr) begin
            m_wp = 0; m_rp = 0; m_wtotal = 0;
         end else begin
            int ra, wa;
            ra = mode ? m_rp : int'(addr);
            wa = mode ? m_wp : int'(addr);
            if (rd) begin
               e_do = m_mem[ra];
               e_valid = 1'b1;
               if (mode) m_rp = (m_rp + 1) % 8;
            end
            if (wr) begin
               if (be[0]) m_mem[wa][7:0]  = di[7:0];
               if (be[1]) m_mem[wa][15:8] = di[15:8];
               m_wtotal = m_wtotal + 1;
               if (m_wtotal % 8 == 0) e_full = 1'b1;
               if (mode) m_wp = (m_wp + 1) % 8;
            end
         end
      end
   end

   // Compare process: every falling edge, DUT vs model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("do", 32'(dout), 32'(e_do));
         check("do_valid", 32'(do_valid), 32'(e_valid));
         check("full", 32'(full), 32'(e_full));
         check("wptr", 32'(wptr), 32'(m_wp));
         check("rptr", 32'(rptr), 32'(m_rp));
      end
   end

   // One cycle of stimulus; returns at the falling edge after the access.
   task automatic op(input logic w, input logic r, input logic md, input logic c,
                     input logic [2:0] a, input logic [15:0] d, input logic [1:0] b);
      wr = w; rd = r; mode = md; clr = c; addr = a; di = d; be = b;
      @(negedge clk);
      if (full) full_seen++;
   endtask

   task automatic idle();
      op(1'b0, 1'b0, mode, 1'b0, 3'd0, 16'h0000, 2'b00);
   endtask

   task automatic rd0(input logic [2:0] a, input logic [15:0] exp, input string nm);
      op(1'b0, 1'b1, 1'b0, 1'b0, a, 16'h0000, 2'b00);
      check(nm, 32'(dout), 32'(exp));
      check({nm, "_valid"}, 32'(do_valid), 32'd1);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      chk_en = 1'b1;
      idle();

      // 1: reset clears data, outputs and any in-flight write
      op(1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 16'hAAAA, 2'b11);
      rd0(3'd3, 16'hAAAA, "t1_pre");
      wr = 1'b1; rd = 1'b1; addr = 3'd3; di = 16'h5555; be = 2'b11;
      #3 rst_n = 1'b0;
      #1;
      check("t1_do", 32'(dout), 32'h0);
      check("t1_valid", 32'(do_valid), 32'h0);
      check("t1_full", 32'(full), 32'h0);
      check("t1_wptr", 32'(wptr), 32'h0);
      check("t1_rptr", 32'(rptr), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      rd0(3'd3, 16'h0000, "t1_post");

      // 2: addressed write/read sweep, FULL every 8 writes
      full_seen = 0;
      for (int i = 0; i < 32; i++) begin
         op(1'b1, 1'b0, 1'b0, 1'b0, 3'(i % 8), 16'hB000 + 16'(i), 2'b11);
         rd0(3'(i % 8), 16'hB000 + 16'(i), "t2_rd");
      end
      check("t2_full_pulses", 32'(full_seen), 32'd4);
      for (int j = 0; j < 8; j++) rd0(3'(j), 16'hB018 + 16'(j), "t2_final");

      // 3: byte enables
      op(1'b1, 1'b0, 1'b0, 1'b0, 3'd5, 16'hFFFF, 2'b11);
      op(1'b1, 1'b0, 1'b0, 1'b0, 3'd5, 16'h1234, 2'b01);
      rd0(3'd5, 16'hFF34, "t3_be01");
      op(1'b1, 1'b0, 1'b0, 1'b0, 3'd5, 16'hAB00, 2'b10);
      rd0(3'd5, 16'hAB34, "t3_be10");
      op(1'b1, 1'b0, 1'b0, 1'b0, 3'd5, 16'h5555, 2'b00);
      rd0(3'd5, 16'hAB34, "t3_be00");

      // 4: circular mode after a clear
      op(1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 16'h0000, 2'b00);
      full_seen = 0;
      for (int i = 0; i < 10; i++) op(1'b1, 1'b0, 1'b1, 1'b0, 3'd7, 16'hC000 + 16'(i), 2'b11);
      check("t4_wptr", 32'(wptr), 32'd2);
      check("t4_full_pulses", 32'(full_seen), 32'd1);
      for (int i = 0; i < 8; i++) begin
         op(1'b0, 1'b1, 1'b1, 1'b0, 3'd7, 16'h0000, 2'b00);
         check("t4_rd", 32'(dout), (i < 2) ? 32'hC008 + 32'(i) : 32'hC000 + 32'(i));
      end
      check("t4_rptr", 32'(rptr), 32'd0);

      // 5: same-cycle read and write is read-first
      op(1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 16'h1111, 2'b11);
      op(1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 16'h2222, 2'b11);
      check("t5_rw", 32'(dout), 32'h1111);
      rd0(3'd2, 16'h2222, "t5_after");

      // 6: clear ignores a same-cycle write and restarts the FULL count
      op(1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 16'h0000, 2'b00);
      for (int i = 0; i < 5; i++) op(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 16'hD000 + 16'(i), 2'b11);
      op(1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 16'hEEEE, 2'b11);
      check("t6_wptr", 32'(wptr), 32'd0);
      check("t6_valid", 32'(do_valid), 32'd0);
      full_seen = 0;
      for (int i = 0; i < 7; i++) op(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 16'h00E0 + 16'(i), 2'b01);
      check("t6_full_early", 32'(full_seen), 32'd0);
      op(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 16'h00E7, 2'b01);
      check("t6_full_8th", 32'(full_seen), 32'd1);
      for (int j = 0; j < 8; j++)
         rd0(3'(j), (j < 5) ? 16'hD0E0 + 16'(j) : 16'hC0E0 + 16'(j), "t6_retain");

      // Random traffic against the model
      for (int n = 0; n < 600; n++) begin
         op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0,
            3'($urandom_range(0, 7)), 16'($urandom), 2'($urandom_range(0, 3)));
      end
      idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
